// File: rtl/score_counter.sv
// Level-weighted score keeper with a base-100 split score word {hi, lo}.
// Also tracks total cleared lines and the current level.
module score_counter #(
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_game,
    input  logic        clr_valid,
    input  logic [2:0]  clr_lines,
    output logic        clr_ready,
    input  logic        drop_pulse,
    output logic [15:0] score,
    output logic [9:0]  lines,
    output logic [3:0]  level,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MUL    = 2'd1;
    localparam logic [1:0] ADD_LO = 2'd2;
    localparam logic [1:0] ADD_HI = 2'd3;

    logic [1:0] state;
    logic [2:0] n_r;
    logic       is_drop;
    logic [6:0] pts;
    logic       carry;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       sat;
    logic [9:0] lines_r;
    logic [3:0] level_r;
    logic [7:0] lines_in_lvl;
    logic       drop_pend;

    logic       clear_ok;
    logic       drop_take;
    logic [2:0] n_clamp;
    logic [3:0] base_pts;
    logic [6:0] prod;
    logic [7:0] lo_sum;
    logic [8:0] hi_sum;
    logic [10:0] lines_sum;
    logic [7:0] lvl_sum;

    // Handshake: an event transfers on a rising edge where clr_valid && clr_ready;
    // the source holds clr_valid (and clr_lines) stable until that edge.
    assign clr_ready = (state == IDLE) && !new_game;
    assign clear_ok  = clr_valid && clr_ready;
    assign drop_take = (state == IDLE) && !clear_ok && drop_pend;
    assign n_clamp   = (clr_lines > 3'd4) ? 3'd4 : clr_lines;

    always_comb begin
        base_pts = 4'd0;
        case (n_r)
            3'd0:    base_pts = 4'd0;
            3'd1:    base_pts = 4'd1;
            3'd2:    base_pts = 4'd3;
            3'd3:    base_pts = 4'd5;
            default: base_pts = 4'd8;
        endcase
    end

    assign prod      = {3'd0, base_pts} * {3'd0, level_r};
    assign lo_sum    = lo + {1'b0, pts};
    assign hi_sum    = {1'b0, hi} + {8'd0, carry};
    assign lines_sum = {1'b0, lines_r} + {8'd0, n_r};
    assign lvl_sum   = lines_in_lvl + {5'd0, n_r};

    always_ff @(posedge clk) begin
        if (!rst_n || new_game) begin
            state        <= IDLE;
            n_r          <= 3'd0;
            is_drop      <= 1'b0;
            pts          <= 7'd0;
            carry        <= 1'b0;
            lo           <= 8'd0;
            hi           <= 8'd0;
            sat          <= 1'b0;
            lines_r      <= 10'd0;
            level_r      <= 4'd1;
            lines_in_lvl <= 8'd0;
            drop_pend    <= 1'b0;
        end else begin
            // A new pulse wins over consumption so a drop is never lost.
            if (drop_pulse) begin
                drop_pend <= 1'b1;
            end else if (drop_take) begin
                drop_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (clear_ok) begin
                        n_r     <= n_clamp;
                        is_drop <= 1'b0;
                        state   <= MUL;
                    end else if (drop_pend) begin
                        n_r     <= 3'd0;
                        is_drop <= 1'b1;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    pts   <= is_drop ? 7'd1 : prod;
                    state <= ADD_LO;
                end
                ADD_LO: begin
                    if (!sat) begin
                        if (lo_sum >= 8'd100) begin
                            lo    <= lo_sum - 8'd100;
                            carry <= 1'b1;
                        end else begin
                            lo    <= lo_sum;
                            carry <= 1'b0;
                        end
                    end
                    state <= ADD_HI;
                end
                ADD_HI: begin
                    // Once saturated the score is frozen at 99:99 until a new game.
                    if (!sat) begin
                        if (hi_sum > 9'd99) begin
                            hi  <= 8'd99;
                            lo  <= 8'd99;
                            sat <= 1'b1;
                        end else begin
                            hi <= hi_sum[7:0];
                        end
                    end
                    if (!is_drop) begin
                        lines_r <= (lines_sum > 11'd999) ? 10'd999 : lines_sum[9:0];
                        if (lvl_sum >= LINES_PER_LEVEL[7:0]) begin
                            lines_in_lvl <= lvl_sum - LINES_PER_LEVEL[7:0];
                            if (level_r < MAX_LEVEL[3:0]) begin
                                level_r <= level_r + 4'd1;
                            end
                        end else begin
                            lines_in_lvl <= lvl_sum;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign score     = {hi, lo};
    assign lines     = lines_r;
    assign level     = level_r;
    assign fsm_state = state;

endmodule
